uart_rx_param: RTL and testbench

//  Parametrised UART receiver; next generation of the fixed 8-bit receiver. Oversamples the serial line,

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_bit_timer.sv | 35 +++
 rtl/uart_rx_param.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART receiver: FSM state encoding,
// parity mode constants and the parity check helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5,
        ST_BREAK  = 3'd6
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // acc is the XOR of all data bits; odd mode wants acc^bit == 1, even wants 0
    function automatic logic parity_err_f(input logic acc, input logic bit_in, input int mode);
        logic w_err;
        if (mode == PARITY_NONE) begin
            w_err = 1'b0;
        end else begin
            w_err = ((acc ^ bit_in) != (mode == PARITY_ODD));
        end
        return w_err;
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Free-running bit-period counter with a synchronous clear; flags the
// half-bit point (start-bit centre) and the end of each full bit period.
module uart_rx_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_half_tick,
    output logic o_full_tick
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_CNT = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_CNT = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] r_count;

    // Counter wraps at the terminal count so consecutive bits stay phase-aligned
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= {TW{1'b0}};
        end else if (i_clear) begin
            r_count <= {TW{1'b0}};
        end else if (r_count == FULL_CNT) begin
            r_count <= {TW{1'b0}};
        end else begin
            r_count <= r_count + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    assign o_half_tick = (r_count == HALF_CNT);
    assign o_full_tick = (r_count == FULL_CNT);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: synchroniser, frame FSM,
// shift/parity datapath and a valid/ready output register with error flags.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 2,
    parameter int STOP_BITS    = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 w_tmr_clr;
    logic                 w_half_tick;
    logic                 w_full_tick;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_xor;
    logic                 r_perr;
    logic                 r_ferr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr_out;
    logic                 r_ferr_out;
    logic                 r_overrun;
    logic                 r_busy;

    uart_rx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_tmr_clr),
        .o_half_tick (w_half_tick),
        .o_full_tick (w_full_tick)
    );

    // Two-flop synchroniser for the asynchronous serial line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_rx_s  <= r_sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the timer is held cleared whenever no bit is being timed
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_tmr_clr = 1'b1;
                if (!r_rx_s) w_state_nxt = ST_START;
                else         w_state_nxt = ST_IDLE;
            end
            ST_START: begin
                if (w_half_tick) begin
                    if (r_rx_s) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DATA;
                        w_tmr_clr   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_full_tick && (r_bit_cnt == LAST_DATA))
                    w_state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                else
                    w_state_nxt = ST_DATA;
            end
            ST_PARITY: begin
                if (w_full_tick) w_state_nxt = ST_STOP;
                else             w_state_nxt = ST_PARITY;
            end
            ST_STOP: begin
                if (w_full_tick && (r_bit_cnt == LAST_STOP)) w_state_nxt = ST_DONE;
                else                                         w_state_nxt = ST_STOP;
            end
            ST_DONE: begin
                w_tmr_clr = 1'b1;
                if (r_rx_s) w_state_nxt = ST_IDLE;
                else        w_state_nxt = ST_BREAK;
            end
            ST_BREAK: begin
                w_tmr_clr = 1'b1;
                if (r_rx_s) w_state_nxt = ST_IDLE;
                else        w_state_nxt = ST_BREAK;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tmr_clr   = 1'b1;
            end
        endcase
    end

    // Shift register, running parity and per-frame error capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt <= {BW{1'b0}};
            r_shift   <= {DATA_BITS{1'b0}};
            r_xor     <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            case (r_state)
                ST_START: begin
                    r_bit_cnt <= {BW{1'b0}};
                    r_xor     <= 1'b0;
                    r_perr    <= 1'b0;
                    r_ferr    <= 1'b0;
                end
                ST_DATA: begin
                    if (w_full_tick) begin
                        if (MSB_FIRST != 0) r_shift <= {r_shift[DATA_BITS-2:0], r_rx_s};
                        else                r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        r_xor <= r_xor ^ r_rx_s;
                        if (r_bit_cnt == LAST_DATA) r_bit_cnt <= {BW{1'b0}};
                        else                        r_bit_cnt <= r_bit_cnt + {{(BW-1){1'b0}}, 1'b1};
                    end else begin
                        r_bit_cnt <= r_bit_cnt;
                    end
                end
                ST_PARITY: begin
                    if (w_full_tick) r_perr <= parity_err_f(r_xor, r_rx_s, PARITY_MODE);
                    else             r_perr <= r_perr;
                end
                ST_STOP: begin
                    if (w_full_tick) begin
                        if (!r_rx_s) r_ferr <= 1'b1;
                        else         r_ferr <= r_ferr;
                        if (r_bit_cnt == LAST_STOP) r_bit_cnt <= {BW{1'b0}};
                        else                        r_bit_cnt <= r_bit_cnt + {{(BW-1){1'b0}}, 1'b1};
                    end else begin
                        r_bit_cnt <= r_bit_cnt;
                    end
                end
                default: begin
                    r_bit_cnt <= r_bit_cnt;
                end
            endcase
        end
    end

    // Output register: a completed frame is dropped if the previous word is still pending
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data     <= {DATA_BITS{1'b0}};
            r_valid    <= 1'b0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_overrun  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_busy    <= (w_state_nxt != ST_IDLE);
            if (r_state == ST_DONE) begin
                if (!r_valid || rx_ready) begin
                    r_data     <= r_shift;
                    r_perr_out <= r_perr;
                    r_ferr_out <= r_ferr;
                    r_valid    <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign rx_data    = r_data;
    assign rx_valid   = r_valid;
    assign parity_err = r_perr_out;
    assign frame_err  = r_ferr_out;
    assign overrun    = r_overrun;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations driven from a serial frame
// generator; received words are compared with expectations from frame rules.
module tb_uart_rx_param;

    localparam int CPB = 16;

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } rec_t;

    typedef struct {
        int         idx;
        logic [8:0] w;
        logic       pb;
        logic       stop_low;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] rx_l;
    logic [2:0] rdy;
    logic [7:0] d0, d1;
    logic [8:0] d2;
    logic       v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2, b0, b1, b2;

    rec_t mon_q[$];
    int   ov_cnt0 = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // A: 8 data, even, 1 stop, MSB first
    uart_rx_param u_a (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_l[0]), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy[0]),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0), .busy(b0));
    // B: 8 data, odd, 1 stop, LSB first
    uart_rx_param #(.PARITY_MODE(1), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_l[1]), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy[1]),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1));
    // C: 9 data, even, 2 stop, MSB first
    uart_rx_param #(.DATA_BITS(9), .STOP_BITS(2)) u_c (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_l[2]), .rx_data(d2), .rx_valid(v2), .rx_ready(rdy[2]),
        .parity_err(pe2), .frame_err(fe2), .overrun(ov2), .busy(b2));

    function automatic rec_t mk(input int i, input logic [8:0] d, input logic p, input logic f);
        rec_t t;
        t.inst = i; t.data = d; t.perr = p; t.ferr = f;
        return t;
    endfunction

    // Record every accepted word and every overrun pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (v0 && rdy[0]) mon_q.push_back(mk(0, {1'b0, d0}, pe0, fe0));
        if (v1 && rdy[1]) mon_q.push_back(mk(1, {1'b0, d1}, pe1, fe1));
        if (v2 && rdy[2]) mon_q.push_back(mk(2, d2, pe2, fe2));
        if (ov0) ov_cnt0 = ov_cnt0 + 1;
    end

    function automatic int nb_of(input int i);  return (i == 2) ? 9 : 8; endfunction
    function automatic bit msb_of(input int i); return (i != 1);         endfunction
    function automatic int pm_of(input int i);  return (i == 1) ? 1 : 2; endfunction
    function automatic int ns_of(input int i);  return (i == 2) ? 2 : 1; endfunction

    // Parity rule: the total count of ones (data + parity bit) must be odd for odd mode, even for even mode
    function automatic logic model_perr(input int pm, input logic [8:0] w, input int n, input logic pb);
        int ones = 0;
        for (int k = 0; k < n; k++) ones += int'(w[k]);
        ones += int'(pb);
        if (pm == 0) return 1'b0;
        return ((ones % 2) == 1) ? (pm == 2) : (pm == 1);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input int idx, input logic [8:0] w, input logic pb, input logic stop_low);
        logic bits[$];
        int n = nb_of(idx);
        bits.push_back(1'b0);
        for (int k = 0; k < n; k++) bits.push_back(msb_of(idx) ? w[n-1-k] : w[k]);
        if (pm_of(idx) != 0) bits.push_back(pb);
        for (int s = 0; s < ns_of(idx); s++) bits.push_back((stop_low && s == 0) ? 1'b0 : 1'b1);
        foreach (bits[k]) begin
            rx_l[idx] = bits[k];
            tick(CPB);
        end
    endtask

    task automatic get_word(input int idx, output rec_t r);
        int b = 0;
        while (mon_q.size() == 0 && b < 2000) begin
            tick(1);
            b++;
        end
        chk("word_present", int'(mon_q.size() > 0), 1);
        if (mon_q.size() > 0) begin
            r = mon_q.pop_front();
            chk("word_inst", r.inst, idx);
        end else begin
            r = mk(-1, 9'h000, 1'b0, 1'b0);
        end
    endtask

    task automatic frame_check(input int idx, input logic [8:0] w, input logic pb, input logic sl,
                               input logic ep, input logic ef);
        rec_t r;
        send(idx, w, pb, sl);
        rx_l[idx] = 1'b1;
        tick(2 * CPB);
        get_word(idx, r);
        chk("data", int'(r.data), int'(w));
        chk("parity_err", int'(r.perr), int'(ep));
        chk("frame_err", int'(r.ferr), int'(ef));
        chk("single_word", mon_q.size(), 0);
    endtask

    vec_t tbl[11];

    initial begin
        rec_t r;
        int   ov_before;
        tbl[0]  = '{0, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1, 9'h03C, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{0, 9'h0FF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{0, 9'h001, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1, 9'h080, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1, 9'h0FF, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{0, 9'h05A, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{2, 9'h0AB, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{2, 9'h0AB, 1'b1, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        rx_l  = 3'b111;
        rdy   = 3'b111;
        tick(3);
        chk("rst_valid", int'({v0, v1, v2}), 0);
        chk("rst_busy", int'({b0, b1, b2}), 0);
        chk("rst_flags", int'({pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2}), 0);
        chk("rst_data", int'({d0, d1, d2}), 0);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 11; i++)
            frame_check(tbl[i].idx, tbl[i].w, tbl[i].pb, tbl[i].stop_low, tbl[i].exp_perr, tbl[i].exp_ferr);

        // Stop bit low followed by a long break: one flagged word, busy until release
        send(0, 9'h0C3, 1'b0, 1'b1);
        tick(40 * CPB);
        chk("break_busy", int'(b0), 1);
        get_word(0, r);
        chk("break_ferr", int'(r.ferr), 1);
        chk("break_data", int'(r.data), 'hC3);
        rx_l[0] = 1'b1;
        tick(5);
        chk("break_release_busy", int'(b0), 0);
        tick(2 * CPB);
        chk("break_no_second", mon_q.size(), 0);

        // Short glitch on the line is rejected
        rx_l[0] = 1'b0;
        tick(5);
        rx_l[0] = 1'b1;
        tick(CPB / 2 + 3);
        chk("glitch_busy", int'(b0), 0);
        tick(2 * CPB);
        chk("glitch_no_word", mon_q.size(), 0);
        chk("glitch_valid", int'(v0), 0);

        // Overrun: second word dropped while the first is held
        rdy[0]    = 1'b0;
        ov_before = ov_cnt0;
        send(0, 9'h011, 1'b0, 1'b0);
        tick(2 * CPB);
        send(0, 9'h022, 1'b0, 1'b0);
        tick(2 * CPB);
        chk("ovr_data_held", int'(d0), 'h11);
        chk("ovr_valid_held", int'(v0), 1);
        chk("ovr_pulses", ov_cnt0 - ov_before, 1);
        rdy[0] = 1'b1;
        tick(2);
        get_word(0, r);
        chk("ovr_accepted", int'(r.data), 'h11);
        tick(2 * CPB);
        chk("ovr_dropped", mon_q.size(), 0);
        chk("ovr_valid_clear", int'(v0), 0);

        // Reset mid-frame on the 9-bit, 2-stop receiver
        rx_l[2] = 1'b0;
        tick(4 * CPB);
        chk("mid_busy", int'(b2), 1);
        rst_n = 1'b0;
        tick(2);
        chk("mid_rst_busy", int'(b2), 0);
        chk("mid_rst_valid", int'(v2), 0);
        chk("mid_rst_data", int'(d2), 0);
        rx_l[2] = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(3 * CPB);
        chk("mid_rst_no_word", mon_q.size(), 0);
        frame_check(2, 9'h1FF, 1'b1, 1'b0, 1'b0, 1'b0);

        // Random frames against the frame-rule model
        for (int i = 0; i < 40; i++) begin
            int         idx = $urandom_range(0, 2);
            logic [8:0] w   = 9'($urandom) & ((idx == 2) ? 9'h1FF : 9'h0FF);
            logic       pb  = 1'($urandom_range(0, 1));
            logic       sl  = ($urandom_range(0, 7) == 0);
            frame_check(idx, w, pb, sl, model_perr(pm_of(idx), w, nb_of(idx), pb), sl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
